// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the instruction/data memory arbiter.
//   arb_state  : arbiter FSM state encoding (idle, serving imem, serving dmem)
//   mem_req_t  : one captured memory request (address, byte masks, store data)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam int PKG_MASK_W = PKG_DATA_W / 8;

    typedef logic [1:0] arb_state;

    localparam arb_state arb_idle  = 2'd0;
    localparam arb_state arb_ibusy = 2'd1;
    localparam arb_state arb_dbusy = 2'd2;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_MASK_W-1:0] rmask;
        logic [PKG_MASK_W-1:0] wmask;
        logic [PKG_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the pipeline-side imem/dmem ports and the single memory port.
//   slave  : the arbiter's view (takes pipeline requests, drives memory)
//   master : the environment's view (pipeline + memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  imem_req;
    logic [ADDR_W-1:0]     imem_addr;
    logic [DATA_W-1:0]     imem_rdata;
    logic                  imem_resp;

    logic                  dmem_req;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W/8-1:0]   dmem_rmask;
    logic [DATA_W/8-1:0]   dmem_wmask;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W-1:0]     dmem_rdata;
    logic                  dmem_resp;

    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_rmask;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_resp,
        input  dmem_req, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_resp,
        output dmem_req, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/mem_arbiter_req_latch.sv
// -----------------------------------------------------------------------------
// mem_req_latch
// Pending-request register for one arbiter port.
//   clk, rst   : clock, synchronous active-high reset
//   capture    : request pulse from the pipeline; loads req_in
//   clear      : the port's transaction completed this cycle
//   req_in     : request fields presented with capture
//   valid      : a request is pending or in flight
//   eff_valid  : valid, or a request arriving this cycle
//   eff_req    : the registered request, or req_in when nothing is held
// KEEP_ON_RESET lets a request arriving during reset survive it (used for the
// reset-vector fetch on the imem port).
// -----------------------------------------------------------------------------
module mem_req_latch
    import mem_arbiter_pkg::*;
#(
    parameter bit KEEP_ON_RESET = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     capture,
    input  logic     clear,
    input  mem_req_t req_in,
    output logic     valid,
    output logic     eff_valid,
    output mem_req_t eff_req
);

    mem_req_t req_q;

    // Data is loaded on every capture, reset included, so a reset-vector
    // fetch keeps its address.
    always_ff @(posedge clk) begin
        if (capture) begin
            req_q <= req_in;
        end
    end

    // A capture coinciding with the completion of the previous transaction
    // must win, otherwise that new request would be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= KEEP_ON_RESET ? capture : 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Bypass lets an idle arbiter issue a request on the same edge it is captured.
    assign eff_valid = valid | capture;
    assign eff_req   = valid ? req_q : req_in;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Merges the instruction-fetch port and the load/store port onto a single
// memory port with at most one transaction outstanding; dmem has priority.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying imem_*, dmem_* and mem_* signals
// mem_* request outputs are registered; responses are combinational
// pass-through of mem_resp / mem_rdata to the port that owns the transaction.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int DATA_W = PKG_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int MASK_W = DATA_W / 8;

    arb_state            state;
    logic [ADDR_W-1:0]   addr_q;
    logic [MASK_W-1:0]   rmask_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   wdata_q;

    mem_req_t            i_in, d_in, i_eff, d_eff, issue_req;
    logic                i_valid, d_valid, i_eff_valid, d_eff_valid;
    logic                i_done, d_done, issue;

    // Instruction fetches are always full-word reads.
    always_comb begin
        i_in       = '0;
        i_in.addr  = bus.imem_addr;
        i_in.rmask = '1;
        d_in       = '0;
        d_in.addr  = bus.dmem_addr;
        d_in.rmask = bus.dmem_rmask;
        d_in.wmask = bus.dmem_wmask;
        d_in.wdata = bus.dmem_wdata;
    end

    assign i_done = !rst && (state == arb_ibusy) && bus.mem_resp;
    assign d_done = !rst && (state == arb_dbusy) && bus.mem_resp;

    mem_req_latch #(.KEEP_ON_RESET(1'b1)) u_imem_latch (
        .clk       (clk),
        .rst       (rst),
        .capture   (bus.imem_req),
        .clear     (i_done),
        .req_in    (i_in),
        .valid     (i_valid),
        .eff_valid (i_eff_valid),
        .eff_req   (i_eff)
    );

    mem_req_latch #(.KEEP_ON_RESET(1'b0)) u_dmem_latch (
        .clk       (clk),
        .rst       (rst),
        .capture   (bus.dmem_req),
        .clear     (d_done),
        .req_in    (d_in),
        .valid     (d_valid),
        .eff_valid (d_eff_valid),
        .eff_req   (d_eff)
    );

    assign issue     = !rst && (state == arb_idle) && (d_eff_valid || i_eff_valid);
    assign issue_req = d_eff_valid ? d_eff : i_eff;

    // Masks are single-cycle strobes; anything other than an issue edge zeroes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= arb_idle;
            rmask_q <= '0;
            wmask_q <= '0;
        end else begin
            rmask_q <= '0;
            wmask_q <= '0;
            case (state)
                arb_idle: begin
                    if (issue) begin
                        state   <= d_eff_valid ? arb_dbusy : arb_ibusy;
                        rmask_q <= issue_req.rmask;
                        wmask_q <= issue_req.wmask;
                    end
                end
                arb_ibusy: if (bus.mem_resp) state <= arb_idle;
                arb_dbusy: if (bus.mem_resp) state <= arb_idle;
                default:   state <= arb_idle;
            endcase
        end
    end

    // Address and store data simply hold between issues.
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_q  <= issue_req.addr;
            wdata_q <= issue_req.wdata;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_rmask  = rmask_q;
    assign bus.mem_wmask  = wmask_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.imem_resp  = i_done;
    assign bus.dmem_resp  = d_done;
    assign bus.imem_rdata = bus.mem_rdata;
    assign bus.dmem_rdata = bus.mem_rdata;

    // A port may re-request in the cycle its own response arrives, never earlier.
    imem_req_while_busy: assert property (@(posedge clk) disable iff (rst)
        bus.imem_req |-> (!i_valid || i_done));
    dmem_req_while_busy: assert property (@(posedge clk) disable iff (rst)
        bus.dmem_req |-> (!d_valid || d_done));
    dmem_req_no_mask: assert property (@(posedge clk) disable iff (rst)
        bus.dmem_req |-> ((bus.dmem_rmask != '0) || (bus.dmem_wmask != '0)));

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Expected memory issues are queued when
// a request is driven and compared when the arbiter puts them on mem_*.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    mem_req_t exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Hard time limit in case the DUT wedges the flow somewhere unbounded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge; registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_imem(input logic [31:0] addr);
        mem_req_t e;
        bus.imem_req  = 1'b1;
        bus.imem_addr = addr;
        e = '0;
        e.addr  = addr;
        e.rmask = 4'hf;
        exp_q.push_back(e);
    endtask

    task automatic apply_dmem(input logic [31:0] addr, input logic [3:0] rmask,
                              input logic [3:0] wmask, input logic [31:0] wdata);
        mem_req_t e;
        bus.dmem_req   = 1'b1;
        bus.dmem_addr  = addr;
        bus.dmem_rmask = rmask;
        bus.dmem_wmask = wmask;
        bus.dmem_wdata = wdata;
        e.addr  = addr;
        e.rmask = rmask;
        e.wmask = wmask;
        e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    task automatic check_masks_idle(input string tag);
        check_val({tag, "_rmask"}, {28'h0, bus.mem_rmask}, 32'h0);
        check_val({tag, "_wmask"}, {28'h0, bus.mem_wmask}, 32'h0);
    endtask

    // Compare the transaction currently on mem_* with the oldest expected one.
    task automatic check_output(input string tag);
        mem_req_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s_unexpected: observed an issue at %h, expected none", tag, bus.mem_addr);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val({tag, "_addr"},  bus.mem_addr, e.addr);
            check_val({tag, "_rmask"}, {28'h0, bus.mem_rmask}, {28'h0, e.rmask});
            check_val({tag, "_wmask"}, {28'h0, bus.mem_wmask}, {28'h0, e.wmask});
            if (e.wmask != 4'h0) check_val({tag, "_wdata"}, bus.mem_wdata, e.wdata);
        end
    endtask

    // Wait (bounded) for an issue and check both its timing and its contents.
    task automatic wait_issue(input int max_wait, input int exp_wait, input string tag);
        int n = 0;
        while (bus.mem_rmask == 4'h0 && bus.mem_wmask == 4'h0 && n < max_wait) begin
            tick();
            n++;
        end
        checks++;
        assert (bus.mem_rmask != 4'h0 || bus.mem_wmask != 4'h0) else begin
            errors++;
            $error("[TB] FAIL %s_timeout: observed no issue in %0d cycles, expected one after %0d", tag, n, exp_wait);
        end
        if (bus.mem_rmask != 4'h0 || bus.mem_wmask != 4'h0) begin
            check_val({tag, "_latency"}, n, exp_wait);
            check_output(tag);
        end
    endtask

    // Wait lat cycles from the issue cycle, then pulse mem_resp and check routing.
    // Leaves mem_resp high; the caller drops it after the next tick.
    task automatic serve(input int lat, input logic [31:0] data,
                         input logic exp_i, input logic exp_d, input string tag);
        repeat (lat) tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = data;
        #1;
        check_val({tag, "_imem_resp"}, {31'h0, bus.imem_resp}, {31'h0, exp_i});
        check_val({tag, "_dmem_resp"}, {31'h0, bus.dmem_resp}, {31'h0, exp_d});
        if (exp_i) check_val({tag, "_imem_rdata"}, bus.imem_rdata, data);
        if (exp_d) check_val({tag, "_dmem_rdata"}, bus.dmem_rdata, data);
    endtask

    initial begin
        int lat, lat2, k;
        logic [31:0] rdata;

        rst            = 1'b1;
        bus.imem_req   = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_req   = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        bus.dmem_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;

        // Reset: masks zero, responses suppressed even with mem_resp high.
        tick();
        tick();
        bus.mem_resp = 1'b1;
        #1;
        check_masks_idle("reset");
        check_val("reset_imem_resp", {31'h0, bus.imem_resp}, 32'h0);
        check_val("reset_dmem_resp", {31'h0, bus.dmem_resp}, 32'h0);
        tick();
        bus.mem_resp = 1'b0;

        // Reset-vector fetch presented in the final reset cycle.
        apply_imem(32'h1eceb000);
        tick();
        rst          = 1'b0;
        bus.imem_req = 1'b0;
        check_masks_idle("post_reset_first");
        wait_issue(5, 1, "reset_vector");
        serve(3, 32'h00000013, 1'b1, 1'b0, "reset_vector");
        tick();
        bus.mem_resp = 1'b0;
        tick();

        // Simultaneous requests: dmem first, imem two cycles after its response.
        apply_dmem(32'h00000100, 4'hf, 4'h0, 32'h0);
        apply_imem(32'h1eceb004);
        tick();
        bus.dmem_req = 1'b0;
        bus.imem_req = 1'b0;
        wait_issue(3, 0, "both_d");
        serve(2, 32'hcafe0001, 1'b0, 1'b1, "both_d");
        tick();
        bus.mem_resp = 1'b0;
        wait_issue(5, 1, "both_i");
        serve(1, 32'h00000093, 1'b1, 1'b0, "both_i");
        tick();
        bus.mem_resp = 1'b0;

        // Partial-word store: a single-cycle write strobe.
        apply_dmem(32'h00000200, 4'h0, 4'h3, 32'hdeadbeef);
        tick();
        bus.dmem_req = 1'b0;
        wait_issue(3, 0, "store");
        tick();
        check_masks_idle("store_one_cycle");
        serve(1, 32'h12345678, 1'b0, 1'b1, "store");
        tick();
        bus.mem_resp = 1'b0;

        // dmem arrives while the fetch is in flight, up to the fetch's response cycle.
        for (int p = 0; p < 200; p++) begin
            lat  = $urandom_range(1, 4);
            lat2 = $urandom_range(1, 4);
            k    = $urandom_range(0, lat);
            apply_imem($urandom & 32'hfffffffc);
            tick();
            bus.imem_req = 1'b0;
            wait_issue(3, 0, "pair_i");
            for (int t = 0; t <= lat; t++) begin
                if (t > 0) check_masks_idle("pair_busy");
                if (t == k) begin
                    if ($urandom_range(0, 1) == 1)
                        apply_dmem($urandom & 32'hfffffffc, 4'h0, 4'($urandom_range(1, 15)), $urandom);
                    else
                        apply_dmem($urandom & 32'hfffffffc, 4'($urandom_range(1, 15)), 4'h0, $urandom);
                end
                if (t == lat) begin
                    rdata         = $urandom;
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = rdata;
                    #1;
                    check_val("pair_i_imem_resp", {31'h0, bus.imem_resp}, 32'h1);
                    check_val("pair_i_dmem_resp", {31'h0, bus.dmem_resp}, 32'h0);
                    check_val("pair_i_imem_rdata", bus.imem_rdata, rdata);
                end
                tick();
                bus.dmem_req = 1'b0;
                bus.mem_resp = 1'b0;
            end
            wait_issue(4, 1, "pair_d");
            serve(lat2, $urandom, 1'b0, 1'b1, "pair_d");
            tick();
            bus.mem_resp = 1'b0;
        end
        check_val("pair_queue_empty", exp_q.size(), 32'h0);

        // Reset in the middle of a dmem transaction abandons it.
        apply_dmem(32'h00000300, 4'hf, 4'h0, 32'h0);
        tick();
        bus.dmem_req = 1'b0;
        wait_issue(3, 0, "rst_mid");
        tick();
        rst = 1'b1;
        #1;
        check_val("rst_mid_dmem_resp_in_rst", {31'h0, bus.dmem_resp}, 32'h0);
        tick();
        rst = 1'b0;
        check_masks_idle("rst_mid_after");
        bus.mem_resp = 1'b1;
        #1;
        check_val("rst_mid_late_dmem_resp", {31'h0, bus.dmem_resp}, 32'h0);
        check_val("rst_mid_late_imem_resp", {31'h0, bus.imem_resp}, 32'h0);
        tick();
        bus.mem_resp = 1'b0;
        check_masks_idle("rst_mid_no_reissue1");
        tick();
        check_masks_idle("rst_mid_no_reissue2");
        apply_imem(32'h00000400);
        tick();
        bus.imem_req = 1'b0;
        wait_issue(2, 0, "post_rst");
        serve(1, 32'h00000513, 1'b1, 1'b0, "post_rst");
        tick();
        bus.mem_resp = 1'b0;

        // Spurious mem_resp while idle is ignored.
        tick();
        bus.mem_resp = 1'b1;
        #1;
        check_val("spurious_imem_resp", {31'h0, bus.imem_resp}, 32'h0);
        check_val("spurious_dmem_resp", {31'h0, bus.dmem_resp}, 32'h0);
        tick();
        bus.mem_resp = 1'b0;
        check_masks_idle("spurious_after");
        apply_dmem(32'h00000500, 4'h1, 4'h0, 32'h0);
        tick();
        bus.dmem_req = 1'b0;
        wait_issue(2, 0, "post_spurious");
        serve(2, 32'h000000ff, 1'b0, 1'b1, "post_spurious");
        tick();
        bus.mem_resp = 1'b0;

        check_val("final_queue_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Merges the pipeline's instruction-fetch port (imem) and load/store port (dmem) onto one single-ported memory interface.
- Sits directly upstream of the stall controller.
  - Returns imem_resp and dmem_resp, which the stall controller consumes to release `move`.
  - Receives the same imem_req and dmem_req pulses that the stall controller sees.
- At most one memory transaction is outstanding at any time. dmem wins when both ports are pending.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width. Mask width is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  in  1  one-cycle fetch request pulse.
- imem_addr  in  ADDR_W  fetch address, valid with imem_req.
- imem_rdata  out  DATA_W  fetch data, valid with imem_resp.
- imem_resp  out  1  fetch completion pulse.
- dmem_req  in  1  one-cycle load/store request pulse.
- dmem_addr  in  ADDR_W  load/store address.
- dmem_rmask  in  DATA_W/8  load byte mask.
- dmem_wmask  in  DATA_W/8  store byte mask.
- dmem_wdata  in  DATA_W  store data.
- dmem_rdata  out  DATA_W  load data, valid with dmem_resp.
- dmem_resp  out  1  load/store completion pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_rmask  out  DATA_W/8  memory read mask. Non-zero for one cycle per read issue.
- mem_wmask  out  DATA_W/8  memory write mask. Non-zero for one cycle per write issue.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_resp  in  1  memory completion pulse.

Behaviour:
- Capture:
  - imem_req and dmem_req are each registered into a per-port pending latch (valid, addr, masks, wdata) on the clock edge where the request is high.
  - Capture is allowed in any state, including while the other port is being served.
  - Asserting a port's req while that port's pending valid or transaction is still outstanding is a protocol violation and must be caught by an assertion.
  - dmem_req with rmask == 0 and wmask == 0 is also a violation.
- FSM states:
  - arb_idle → if d_pend: issue D, go to arb_dbusy. Else if i_pend: issue I, go to arb_ibusy. Else stay.
  - arb_ibusy → on mem_resp: imem_resp = 1, clear i_pend, go to arb_idle. Else stay.
  - arb_dbusy → on mem_resp: dmem_resp = 1, clear d_pend, go to arb_idle. Else stay.
- Issue:
  - mem_addr, mem_rmask, mem_wmask and mem_wdata are registered. They carry the issued transaction for exactly the cycle after the arb_idle decision.
  - In every other cycle the masks are 0. mem_addr and mem_wdata hold their last value.
  - An imem issue drives rmask all-ones and wmask 0.
  - A dmem issue drives the captured rmask and wmask unchanged.
- Latency:
  - Request captured at edge N; mem_* asserted in cycle N+1 at the earliest.
  - Response is combinational pass-through: the port resp and port rdata are high/valid in the same cycle as mem_resp.
  - After a mem_resp in cycle M, the next issue appears no earlier than cycle M+2.
  - Back-to-back minimum per-port round trip is therefore 1 + memory latency.
- Outputs:
  - imem_rdata and dmem_rdata = mem_rdata, always.
  - A resp is asserted only for its port owner.
  - dmem_resp for a store is a plain acknowledge; rdata is don't-care.
- Simultaneous events:
  - Both reqs in the same cycle: both captured; dmem is issued first and imem issues after dmem_resp.
  - A new req arriving in the same cycle as mem_resp for the other port is captured normally.
- mem_resp while in arb_idle (stale or spurious): ignored, no port resp.
- Reset:
  - While rst is high: state ← arb_idle, d_pend ← 0, all masks ← 0, imem_resp = dmem_resp = 0.
  - i_pend ← imem_req, so a reset-vector fetch presented during the final reset cycle is kept. This matches the stall controller's post-reset wait on imem.
  - Reset during arb_ibusy or arb_dbusy abandons the transaction. A later mem_resp for it is ignored.

Decomposition:
- Add `arb_state` {arb_idle, arb_ibusy, arb_dbusy} to the shared rv32i_types package.
- Add a mem_req_t struct {addr, rmask, wmask, wdata} to the same package.
- One sub-module, mem_req_latch, holds the pending register for one port. It is instantiated twice (imem, dmem).

Test Plan:
- Reset, imem_req=1 with imem_addr=0x1eceb000 in the final rst cycle → cycle after reset: mem_addr=0x1eceb000, mem_rmask=4'hf. mem_resp 3 cycles later with mem_rdata=0x00000013 → imem_resp=1, imem_rdata=0x00000013 in that same cycle.
- imem_req and dmem_req both in cycle 5 (dmem load, addr 0x100, rmask 4'hf) → cycle 6 issues the dmem read. After its mem_resp, dmem_resp=1 only; imem issues 2 cycles later.
- dmem store, addr 0x200, wmask 4'h3, wdata 0xdeadbeef → one cycle with mem_wmask=4'h3, mem_rmask=0, mem_wdata=0xdeadbeef. dmem_resp follows mem_resp; imem_resp stays 0.
- dmem_req arrives while arb_ibusy → held pending. imem_resp first, then the dmem issue at M+2; no lost or duplicated requests over 200 random back-to-back pairs.
- rst asserted mid arb_dbusy, then mem_resp → no dmem_resp, state arb_idle, masks 0.
- Spurious mem_resp in arb_idle → no port resp, no state change.
